// File: rtl/add_subtr_pkg.sv
// Shared definitions for the chunk-serial adder/subtractor: FSM encoding,
// a constant clog2 and the derived chunk-count / counter-width defaults.
package add_subtr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

  // A single-chunk configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int nch);
    return (clog2(nch) < 1) ? 1 : clog2(nch);
  endfunction

  localparam int B_DEF   = 32;
  localparam int W_DEF   = 8;
  localparam int NCH_DEF = B_DEF / W_DEF;
  localparam int CW_DEF  = cnt_width(NCH_DEF);

endpackage

// File: rtl/rcanbit.sv
// n-bit ripple-carry adder slice; also exposes the carry into its MSB so the
// caller can form signed overflow without re-deriving it.
module rcanbit #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [n:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < n; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout  = c[n];
  assign c_msb = c[n-1];

endmodule

// File: rtl/add_subtr_mc.sv
// Multi-cycle chunk-serial add/sub: one W-bit ripple slice reused B/W times,
// with the inter-chunk carry held in a register.
module add_subtr_mc
  import add_subtr_pkg::*;
#(
  parameter int B = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [B-1:0] x,
  input  logic [B-1:0] y,
  input  logic         add_n,
  output logic         busy,
  output logic         done,
  output logic [B-1:0] s,
  output logic         c_out,
  output logic         ovf
);

  localparam int NCH = B / W;
  localparam int CW  = cnt_width(NCH);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           carry;
  logic [B-1:0]   xr, yr, work, work_nxt;
  logic [W-1:0]   a_chunk, b_chunk, sum_chunk;
  logic           slice_cout, slice_cmsb;
  logic           accept, last;

  // Handshake: start is honoured whenever busy is low (IDLE or DONE);
  // done is a one-cycle pulse, and s/c_out/ovf only change on that edge.
  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(NCH - 1));

  assign a_chunk = xr[int'(cnt)*W +: W];
  assign b_chunk = yr[int'(cnt)*W +: W];

  rcanbit #(.n(W)) u_slice (
    .a     (a_chunk),
    .b     (b_chunk),
    .cin   (carry),
    .sum   (sum_chunk),
    .cout  (slice_cout),
    .c_msb (slice_cmsb)
  );

  always_comb begin
    work_nxt = work;
    work_nxt[int'(cnt)*W +: W] = sum_chunk;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Subtraction is x + ~y + 1: invert y on entry and seed the carry with add_n.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      carry <= 1'b0;
      xr    <= '0;
      yr    <= '0;
      work  <= '0;
      s     <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      xr    <= x;
      yr    <= y ^ {B{add_n}};
      carry <= add_n;
      cnt   <= '0;
    end else if (state == RUN) begin
      work  <= work_nxt;
      carry <= slice_cout;
      if (last) begin
        cnt   <= '0;
        s     <= work_nxt;
        c_out <= slice_cout;
        ovf   <= slice_cout ^ slice_cmsb;
      end else begin
        cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/add_subtr_mc.md
# add_subtr_mc

Multi-cycle, chunk-serial two's-complement adder/subtractor. It processes a B-bit operand pair W bits per clock and carries between chunks through a register, so wide add/sub operations cost B/W cycles of one narrow ripple-carry slice instead of a full-width ripple chain. It sits between operand sources and any datapath consumer that tolerates fixed multi-cycle latency. A start/busy/done handshake frames each operation.

## Interface
Parameters:
- B, 32: total operand/result width; B % W must be 0.
- W, 8: chunk width processed per cycle; 1 ≤ W ≤ B.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only while busy=0.
- x  in  B  operand A; latched on accepted start.
- y  in  B  operand B; latched on accepted start.
- add_n  in  1  0 = x+y, 1 = x−y; latched on accepted start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: result valid and updated.
- s  out  B  result; holds its value until the next done.
- c_out  out  1  carry out of bit B−1. For subtraction, 1 means no borrow.
- ovf  out  1  signed overflow: carry into bit B−1 XOR carry out of bit B−1.

## Operation
- NCH = B/W chunks. Chunk k covers bits [k·W+W−1 : k·W].
- FSM with states IDLE, RUN, DONE.
  - IDLE: busy=0. On start=1, latch x, latch y XOR {B{add_n}}, latch add_n; set carry register = add_n and chunk counter = 0; go to RUN.
  - RUN: busy=1. Each cycle, add chunk[cnt] of the latched x, chunk[cnt] of the inverted-or-not y, and the carry register. Store the W-bit sum into the working register at chunk cnt. Store the slice carry out into the carry register, then increment cnt. When cnt = NCH−1, the final slice also captures the carry into its MSB for ovf. Load s, c_out and ovf from the working values and go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle. A start sampled in this cycle is accepted exactly as in IDLE, entering RUN. Otherwise the FSM returns to IDLE.
- start while busy=1 is ignored and has no effect on the operation in progress.
- The result is modulo 2^B. s, c_out and ovf change only at the edge that raises done; they never show partial results.
- Reset (any time, including mid-RUN): state=IDLE, cnt=0, carry=0. busy=0, done=0, s=0, c_out=0, ovf=0 asynchronously. The partial operation is discarded and no done is issued.

## Timing
- Start is accepted at edge E0. Chunk k is computed in the cycle after E_k and registered at E_{k+1}. done rises after E_NCH.
- Latency is NCH cycles from the accepting edge to done high. busy is high for NCH cycles.
- Throughput is one operation per NCH+1 cycles (start held high continuously: accepted in IDLE or DONE).
- With W=B (NCH=1), latency is 1 cycle.
- The counter width is clog2(NCH), minimum 1. cnt wraps to 0 on leaving RUN.

## Structure
- Shared package add_subtr_pkg holds:
  - state encoding constants (IDLE, RUN, DONE);
  - a clog2 function;
  - the derived NCH and counter-width localparams.
- Sub-module: rcanbit with n=W, one instance as the per-cycle W-bit ripple-carry slice. It must expose the carry into its MSB for ovf. If it does not, the ovf tap is a 1-bit XOR of the MSB inputs and the MSB sum.
- The remainder is FSM, counter, operand/work registers and the output register in add_subtr_mc.

## Test plan
All scenarios use B=16, W=4 unless noted.
- Add: x=0x1234, y=0x0FFF, add_n=0 → after 4 cycles, done=1, s=0x2233, c_out=0, ovf=0. busy is high for exactly 4 cycles.
- Subtract with borrow: x=0x0005, y=0x0007, add_n=1 → s=0xFFFE, c_out=0, ovf=0. Repeat with x=0x0007, y=0x0005 → s=0x0002, c_out=1.
- Boundaries:
  - 0x7FFF+0x0001 → s=0x8000, ovf=1, c_out=0.
  - 0xFFFF+0x0001 → s=0x0000, c_out=1, ovf=0.
  - 0x8000−0x0001 → s=0x7FFF, ovf=1.
- Start while busy: start 0x1111+0x2222, then pulse start at cycle 2 with 0xAAAA+0x5555 → exactly one done, s=0x3333. Start held high → second operation accepted in the DONE cycle, next done 5 cycles after the first.
- Reset mid-RUN: assert rst at cycle 2 of an operation → busy, done, s, c_out, ovf all 0 immediately, with no done. After release, 0x0001+0x0001 → s=0x0002.
- Parameter sweep: W=16 (NCH=1) → done 1 cycle after start. W=1 (NCH=16) → done after 16 cycles. Random operands are checked against a full-width reference model for both add_n values.
